// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU/branch/forwarding encodings and
// the execute-stage control bundle carried in the ID/EX register.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BLT = 2'b10,
    BR_BGE = 2'b11
  } br_type_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RSV_BOTH = 2'b00;
  localparam logic [1:0] RSV_RS1  = 2'b01;
  localparam logic [1:0] RSV_NONE = 2'b10;

  // Control fields held in ID/EX alongside the operands.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [1:0] branch_type;
    logic [2:0] alu_control;
  } ex_ctrl_t;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side inputs, hazard-unit exchange and EX/MEM outputs of the execute stage.
interface execute_stage_if #(parameter int unsigned XLEN = riscv_pkg::XLEN);

  logic            stall_e;
  logic            flush_e;
  logic            RegWriteD;
  logic            MemWriteD;
  logic            JumpD;
  logic            BranchD;
  logic            ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [1:0]      BranchTypeD;
  logic [2:0]      ALUControlD;
  logic [XLEN-1:0] RD1_D;
  logic [XLEN-1:0] RD2_D;
  logic [XLEN-1:0] Imm_Ext_D;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [4:0]      RD_D;
  logic [4:0]      Rs1_D;
  logic [4:0]      Rs2_D;
  logic [1:0]      RS_valid_D;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic [4:0]      Rs1_E;
  logic [4:0]      Rs2_E;
  logic [1:0]      RS_valid_E;
  logic            ResultSrcE0;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output stall_e, flush_e, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, BranchTypeD, ALUControlD, RD1_D, RD2_D, Imm_Ext_D, PCD,
           PCPlus4D, RD_D, Rs1_D, Rs2_D, RS_valid_D, ForwardAE, ForwardBE, ResultW,
    input  Rs1_E, Rs2_E, RS_valid_E, ResultSrcE0, PCSrcE, PCTargetE, RegWriteM,
           MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  stall_e, flush_e, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, BranchTypeD, ALUControlD, RD1_D, RD2_D, Imm_Ext_D, PCD,
           PCPlus4D, RD_D, Rs1_D, Rs2_D, RS_valid_D, ForwardAE, ForwardBE, ResultW,
    output Rs1_E, Rs2_E, RS_valid_E, ResultSrcE0, PCSrcE, PCTargetE, RegWriteM,
           MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/alu.sv
// Combinational XLEN-wide ALU; wrap-around arithmetic, shifts use the low 5 bits of src_b.
module alu #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  localparam int unsigned SHW = 5;

  logic [SHW-1:0] shamt;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_XOR: result = src_a ^ src_b;
      ALU_SLT: result = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLL: result = src_a << shamt;
      ALU_SRL: result = src_a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: ID/EX register, operand forwarding, ALU, branch
// resolution and the EX/MEM register.
module execute_stage #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input logic             clk,
  input logic             rst,
  execute_stage_if.slave  bus
);
  import riscv_pkg::*;

  ex_ctrl_t        ctrl_d;
  ex_ctrl_t        ctrl_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [4:0]      rd_e, rs1_e, rs2_e;
  logic [1:0]      rs_valid_e;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
  logic            br_cond;

  logic            reg_write_m, mem_write_m;
  logic [1:0]      result_src_m;
  logic [4:0]      rd_m;
  logic [XLEN-1:0] alu_result_m, write_data_m, pc_plus4_m;

  always_comb begin
    ctrl_d             = '0;
    ctrl_d.reg_write   = bus.RegWriteD;
    ctrl_d.mem_write   = bus.MemWriteD;
    ctrl_d.jump        = bus.JumpD;
    ctrl_d.branch      = bus.BranchD;
    ctrl_d.alu_src     = bus.ALUSrcD;
    ctrl_d.result_src  = bus.ResultSrcD;
    ctrl_d.branch_type = bus.BranchTypeD;
    ctrl_d.alu_control = bus.ALUControlD;
  end

  // ID/EX: a flush inserts a bubble that uses no source registers.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_e) begin
      ctrl_e     <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      rd_e       <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rs_valid_e <= RSV_NONE;
    end else if (!bus.stall_e) begin
      ctrl_e     <= ctrl_d;
      rd1_e      <= bus.RD1_D;
      rd2_e      <= bus.RD2_D;
      imm_e      <= bus.Imm_Ext_D;
      pc_e       <= bus.PCD;
      pc_plus4_e <= bus.PCPlus4D;
      rd_e       <= bus.RD_D;
      rs1_e      <= bus.Rs1_D;
      rs2_e      <= bus.Rs2_D;
      rs_valid_e <= bus.RS_valid_D;
    end
  end

  // Forwarding muxes; the unused 2'b11 select falls back to the register file.
  always_comb begin
    src_a = rd1_e;
    case (bus.ForwardAE)
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    fwd_b = rd2_e;
    case (bus.ForwardBE)
      FWD_WB:  fwd_b = bus.ResultW;
      FWD_MEM: fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b = ctrl_e.alu_src ? imm_e : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .alu_control (ctrl_e.alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (alu_result)
  );

  always_comb begin
    br_cond = 1'b0;
    case (ctrl_e.branch_type)
      BR_BEQ:  br_cond = (src_a == fwd_b);
      BR_BNE:  br_cond = (src_a != fwd_b);
      BR_BLT:  br_cond = ($signed(src_a) <  $signed(fwd_b));
      BR_BGE:  br_cond = ($signed(src_a) >= $signed(fwd_b));
      default: br_cond = 1'b0;
    endcase
  end

  // EX/MEM: a stall sends a bubble into MEM while the data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
    end else if (bus.stall_e) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else begin
      reg_write_m  <= ctrl_e.reg_write;
      mem_write_m  <= ctrl_e.mem_write;
      result_src_m <= ctrl_e.result_src;
      rd_m         <= rd_e;
      alu_result_m <= alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
    end
  end

  assign bus.Rs1_E       = rs1_e;
  assign bus.Rs2_E       = rs2_e;
  assign bus.RS_valid_E  = rs_valid_e;
  assign bus.ResultSrcE0 = ctrl_e.result_src[0];
  assign bus.PCSrcE      = ctrl_e.jump | (ctrl_e.branch & br_cond);
  assign bus.PCTargetE   = pc_e + imm_e;
  assign bus.RegWriteM   = reg_write_m;
  assign bus.MemWriteM   = mem_write_m;
  assign bus.ResultSrcM  = result_src_m;
  assign bus.RD_M        = rd_m;
  assign bus.ALUResultM  = alu_result_m;
  assign bus.WriteDataM  = write_data_m;
  assign bus.PCPlus4M    = pc_plus4_m;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_execute_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst;

  execute_stage_if bus ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src, branch_type, rs_valid;
    logic [2:0]  alu_control;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } instr_t;

  int total = 0;
  int bad   = 0;

  instr_t      d, e_m;
  logic        r, stall, flush, was_stall;
  logic [1:0]  fa, fb;
  logic [31:0] res_w;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t nop_i();
    instr_t i;
    i = '{default: '0};
    i.rs_valid = 2'b10;
    return i;
  endfunction

  function automatic instr_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic src);
    instr_t i;
    i = '{default: '0};
    i.alu_control = op;
    i.rd1 = a; i.rd2 = b; i.imm = imm; i.alu_src = src;
    i.reg_write = 1'b1; i.rd = 5'd3; i.rs1 = 5'd1; i.rs2 = 5'd2;
    i.pc = 32'h40; i.pc4 = 32'h44;
    return i;
  endfunction

  function automatic instr_t rnd_i();
    instr_t i;
    i.reg_write = 1'($urandom); i.mem_write = 1'($urandom);
    i.jump = ($urandom_range(0, 7) == 0); i.branch = 1'($urandom);
    i.alu_src = 1'($urandom);
    i.result_src = 2'($urandom); i.branch_type = 2'($urandom);
    i.rs_valid = 2'($urandom_range(0, 2)); i.alu_control = 3'($urandom);
    i.rd1 = $urandom;
    i.rd2 = ($urandom_range(0, 3) == 0) ? i.rd1 : $urandom;
    i.imm = $urandom; i.pc = $urandom; i.pc4 = i.pc + 32'd4;
    i.rd = 5'($urandom); i.rs1 = 5'($urandom); i.rs2 = 5'($urandom);
    return i;
  endfunction

  // Reference ALU computed from the operation's meaning on integers.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return res_w;
    if (sel == 2'b10) return m_alu;
    return rf;
  endfunction

  function automatic logic taken(input instr_t i, input logic [31:0] a, input logic [31:0] b);
    if (i.jump) return 1'b1;
    if (!i.branch) return 1'b0;
    case (i.branch_type)
      2'd0: return a == b;
      2'd1: return a != b;
      2'd2: return int'(a) < int'(b);
      default: return int'(a) >= int'(b);
    endcase
  endfunction

  task automatic drive();
    rst = r;
    bus.stall_e = stall; bus.flush_e = flush;
    bus.RegWriteD = d.reg_write; bus.MemWriteD = d.mem_write;
    bus.JumpD = d.jump; bus.BranchD = d.branch; bus.ALUSrcD = d.alu_src;
    bus.ResultSrcD = d.result_src; bus.BranchTypeD = d.branch_type;
    bus.ALUControlD = d.alu_control;
    bus.RD1_D = d.rd1; bus.RD2_D = d.rd2; bus.Imm_Ext_D = d.imm;
    bus.PCD = d.pc; bus.PCPlus4D = d.pc4;
    bus.RD_D = d.rd; bus.Rs1_D = d.rs1; bus.Rs2_D = d.rs2; bus.RS_valid_D = d.rs_valid;
    bus.ForwardAE = fa; bus.ForwardBE = fb; bus.ResultW = res_w;
  endtask

  // Drive inputs at the falling edge and check E-stage combinational outputs.
  task automatic apply();
    logic [31:0] a, b;
    drive();
    #1;
    a = pick(fa, e_m.rd1);
    b = pick(fb, e_m.rd2);
    check("rs1_e",      32'(bus.Rs1_E),       32'(e_m.rs1));
    check("rs2_e",      32'(bus.Rs2_E),       32'(e_m.rs2));
    check("rs_valid_e", 32'(bus.RS_valid_E),  32'(e_m.rs_valid));
    check("rsrc_e0",    32'(bus.ResultSrcE0), 32'(e_m.result_src[0]));
    check("pcsrc_e",    32'(bus.PCSrcE),      32'(taken(e_m, a, b)));
    check("pctarget_e", bus.PCTargetE,        e_m.pc + e_m.imm);
  endtask

  // Advance the model one instruction slot, clock the DUT, check MEM outputs.
  task automatic advance();
    logic [31:0] a, b, sb;
    a  = pick(fa, e_m.rd1);
    b  = pick(fb, e_m.rd2);
    sb = e_m.alu_src ? e_m.imm : b;
    if (r) begin
      m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
    end else if (stall) begin
      m_rw = 0; m_mw = 0; m_rs = 0;
    end else begin
      m_rw = e_m.reg_write; m_mw = e_m.mem_write; m_rs = e_m.result_src;
      m_rd = e_m.rd; m_alu = alu_ref(e_m.alu_control, a, sb); m_wd = b; m_pc4 = e_m.pc4;
    end
    was_stall = stall && !r;
    if (r || flush) e_m = nop_i();
    else if (!stall) e_m = d;
    @(posedge clk);
    @(negedge clk);
    check("regwrite_m",  32'(bus.RegWriteM),  32'(m_rw));
    check("memwrite_m",  32'(bus.MemWriteM),  32'(m_mw));
    check("resultsrc_m", 32'(bus.ResultSrcM), 32'(m_rs));
    check("aluresult_m", bus.ALUResultM, m_alu);
    check("writedata_m", bus.WriteDataM, m_wd);
    check("pcplus4_m",   bus.PCPlus4M,   m_pc4);
    if (!was_stall) check("rd_m", 32'(bus.RD_M), 32'(m_rd));
  endtask

  task automatic step();
    apply();
    advance();
  endtask

  initial begin
    instr_t bi;
    r = 1'b1; stall = 1'b0; flush = 1'b0; fa = 2'b00; fb = 2'b00; res_w = 32'h1234_5678;
    d = mk(3'd0, 32'hAAAA_0001, 32'h5555_0002, 32'h10, 1'b1);
    d.jump = 1'b1; d.mem_write = 1'b1; d.result_src = 2'b11; d.rs1 = 5'd9;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_regwrite_m",  32'(bus.RegWriteM),  32'd0);
    check("rst_memwrite_m",  32'(bus.MemWriteM),  32'd0);
    check("rst_resultsrc_m", 32'(bus.ResultSrcM), 32'd0);
    check("rst_rd_m",        32'(bus.RD_M),       32'd0);
    check("rst_aluresult_m", bus.ALUResultM,      32'd0);
    check("rst_writedata_m", bus.WriteDataM,      32'd0);
    check("rst_pcplus4_m",   bus.PCPlus4M,        32'd0);
    check("rst_rs_valid_e",  32'(bus.RS_valid_E), 32'd2);
    check("rst_rs1_e",       32'(bus.Rs1_E),      32'd0);
    check("rst_pcsrc_e",     32'(bus.PCSrcE),     32'd0);
    check("rst_pctarget_e",  bus.PCTargetE,       32'd0);
    e_m = nop_i();
    m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
    r = 1'b0;

    // Forwarding from MEM, then from WB.
    d = mk(3'd0, 32'h10, 32'h0, 32'h0, 1'b1); step();
    d = mk(3'd0, 32'h5, 32'h0, 32'h4, 1'b1);  step();
    check("pre_fwd_alu_m", bus.ALUResultM, 32'h10);
    fa = 2'b10; step();
    check("fwd_mem_add", bus.ALUResultM, 32'h14);
    fa = 2'b01; res_w = 32'h7; d = nop_i(); step();
    check("fwd_wb_add", bus.ALUResultM, 32'h0B);
    fa = 2'b00;

    // bne not taken, then taken with redirect target.
    bi = mk(3'd0, 32'h3, 32'h3, 32'h20, 1'b0);
    bi.branch = 1'b1; bi.branch_type = 2'b01; bi.pc = 32'h100;
    d = bi; step();
    d.rd2 = 32'h4; apply();
    check("bne_equal", 32'(bus.PCSrcE), 32'd0);
    advance();
    apply();
    check("bne_taken",  32'(bus.PCSrcE), 32'd1);
    check("bne_target", bus.PCTargetE,   32'h120);
    advance();

    // Signed compare: blt and slt with -1 versus 1.
    bi = mk(3'd5, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    bi.branch = 1'b1; bi.branch_type = 2'b10;
    d = bi; step();
    apply();
    check("blt_signed", 32'(bus.PCSrcE), 32'd1);
    advance();
    check("slt_signed", bus.ALUResultM, 32'd1);

    // Stall twice, then stall together with flush.
    d = mk(3'd0, 32'h1, 32'h2, 32'h3, 1'b0); d.rs1 = 5'd7; d.mem_write = 1'b1; step();
    d = mk(3'd1, 32'h9, 32'h9, 32'h9, 1'b0); d.rs1 = 5'd9; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_rs1_e",    32'(bus.Rs1_E),     32'd7);
      check("stall_regwrite", 32'(bus.RegWriteM), 32'd0);
      check("stall_memwrite", 32'(bus.MemWriteM), 32'd0);
    end
    flush = 1'b1; step();
    check("flush_rs1_e",      32'(bus.Rs1_E),      32'd0);
    check("flush_rs_valid_e", 32'(bus.RS_valid_E), 32'd2);
    stall = 1'b0; flush = 1'b0;

    // Store data forwarded from MEM.
    d = mk(3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1); step();
    d = mk(3'd0, 32'h100, 32'h55, 32'h8, 1'b1); d.mem_write = 1'b1; step();
    fb = 2'b10; d = nop_i(); step();
    check("store_wdata", bus.WriteDataM, 32'hDEAD_BEEF);
    check("store_addr",  bus.ALUResultM, 32'h108);
    check("store_memwr", 32'(bus.MemWriteM), 32'd1);
    fb = 2'b00;

    // Randomized traffic with occasional stall, flush and reset.
    for (int n = 0; n < 400; n++) begin
      d     = rnd_i();
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 8) == 0);
      r     = ($urandom_range(0, 49) == 0);
      fa    = 2'($urandom);
      fb    = 2'($urandom);
      res_w = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RISC-V pipeline, directly downstream of the forwarding/hazard logic. It holds the ID/EX pipeline register and applies the ForwardAE/ForwardBE selections to pick ALU operands. It computes the ALU result and resolves branches/jumps, then registers results into the EX/MEM register. The Rs1_E, Rs2_E and RS_valid_E it exports feed the hazard unit; RD_M and ALUResultM feed both the hazard unit and the forwarding path.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_e  in  1  hold ID/EX contents.
- flush_e  in  1  load a bubble into ID/EX.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode controls.
- ResultSrcD  in  2  result select, passed through.
- BranchTypeD  in  2  00 beq, 01 bne, 10 blt, 11 bge.
- ALUControlD  in  3  ALU op.
- RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D  in  XLEN each  decode operands.
- RD_D, Rs1_D, Rs2_D  in  5 each  register indices.
- RS_valid_D  in  2  source usage: 00 rs1+rs2, 01 rs1 only, 10 none.
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
- ResultW  in  XLEN  writeback value.
- Rs1_E, Rs2_E  out  5  to hazard unit.
- RS_valid_E  out  2  to hazard unit.
- ResultSrcE0  out  1  bit 0 of ResultSrcE, for load-use detection.
- PCSrcE  out  1  redirect taken.
- PCTargetE  out  XLEN  redirect address.
- RegWriteM, MemWriteM  out  1 each.
- ResultSrcM  out  2.
- RD_M  out  5.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each.

## Operation
- ID/EX update priority is rst > flush_e > stall_e > load.
  - rst or flush_e: all E fields become 0, except RS_valid_E = 2'b10.
  - stall_e: ID/EX holds its contents.
  - Otherwise ID/EX loads the D inputs.
- Operand A forwarding (ForwardAE):
  - 00 or 11: RD1_E.
  - 01: ResultW.
  - 10: ALUResultM (the registered EX/MEM value).
- Operand B forwarding (ForwardBE): same encoding, producing fwdB.
- SrcB = ALUSrcE ? Imm_Ext_E : fwdB.
- WriteData is always fwdB.
- ALU operations, width XLEN, wrap-around arithmetic, no overflow flag:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed, result 0/1)
  - 110 sll
  - 111 srl (shift amount = SrcB[4:0])
- Branch condition evaluated on forwarded A and fwdB:
  - beq: A == B.
  - bne: A != B.
  - blt / bge: signed compare.
- PCSrcE = JumpE | (BranchE & cond).
- PCTargetE = PCE + Imm_Ext_E. This also covers jalr when the decoder supplies a jalr-specific target, which is outside this block's scope.
- EX/MEM update priority is rst > stall_e > load.
  - rst: all M outputs 0.
  - stall_e: M controls are zeroed (a bubble enters MEM) and data fields hold.
  - Otherwise EX/MEM loads RegWriteE, MemWriteE, ResultSrcE, RD_E, the ALU result, fwdB and PCPlus4E.
- flush_e does not affect EX/MEM: the instruction currently in E still retires.
- This block does not self-flush after a taken redirect; the hazard unit asserts flush_e using PCSrcE.

## Timing
- D inputs are captured into E at edge N. E results appear on M outputs after edge N+1, a 2-cycle latency from the D inputs.
- PCSrcE, PCTargetE, Rs1_E, Rs2_E, RS_valid_E and ResultSrcE0 are combinational from ID/EX, valid in the same cycle.
- ForwardAE/BE and ResultW are sampled combinationally in E. No input-to-register path exists beyond the ID/EX and EX/MEM registers.
- Simultaneous stall_e and flush_e: flush wins in ID/EX, and EX/MEM still receives a bubble.
- Reset mid-operation clears both registers at the next edge regardless of stall/flush. Outputs take their reset values after that edge.
- Reset values:
  - All outputs 0, except RS_valid_E = 2'b10.
  - PCSrcE = 0.
  - PCTargetE = 0, since PCE and Imm_Ext_E are 0.

## Structure
- Shared package riscv_pkg:
  - ALU op constants.
  - Branch type constants.
  - Forward-select constants (FWD_RF, FWD_WB, FWD_MEM).
  - RS_valid encodings (RSV_BOTH, RSV_RS1, RSV_NONE).
  - XLEN default.
- One sub-module, alu: a combinational XLEN-wide ALU with control input and result output.
- Pipeline registers, forwarding muxes and branch compare stay in execute_stage.

## Test plan
- Reset: assert rst for 2 cycles with nonzero D inputs → all M outputs 0, RS_valid_E = 2'b10, PCSrcE = 0.
- Forwarding: prior instruction leaves ALUResultM = 0x0000_0010; ForwardAE = 10, RD1_E = 5, Imm = 4, ALUSrc = 1, add → ALUResultM = 0x14 after the next edge. Repeating with ForwardAE = 01 and ResultW = 7 → 0x0B.
- Branch: bne with A = 3, B = 3, PCE = 0x100, Imm = 0x20 → PCSrcE = 0. With B = 4 → PCSrcE = 1 and PCTargetE = 0x120 in the same cycle.
- Signed compare: blt with A = 0xFFFF_FFFF, B = 1 → PCSrcE = 1. slt on the same operands → ALUResultM = 1.
- Stall then flush: stall_e = 1 for 2 cycles → E fields unchanged and RegWriteM = 0, MemWriteM = 0 in both following cycles. Then flush_e = 1 together with stall_e = 1 → Rs1_E = 0 and RS_valid_E = 2'b10 after the edge.
- Store data path: MemWriteD = 1, ALUSrcD = 1, ForwardBE = 10, ALUResultM = 0xDEAD_BEEF → WriteDataM = 0xDEAD_BEEF and ALUResultM = rs1 + Imm one edge later.
